// File: rtl/vertex_viewport_mapper.sv
`default_nettype none
// ============================================================================
// Module      : vertex_viewport_mapper
// Description : Perspective divide (x/w, y/w) with a sequential restoring
//               divider, followed by the viewport map to integer screen
//               coordinates with saturation and a clip flag. z passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_viewport_mapper #(
    parameter int M     = 10,
    parameter int N     = 4,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int CW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_x,
    input  logic [M+N-1:0]   in_y,
    input  logic [M+N-1:0]   in_z,
    input  logic [M+N-1:0]   in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_sx,
    output logic [CW-1:0]    out_sy,
    output logic [M+N-1:0]   out_z,
    output logic             out_clip
);

    localparam int c_dw   = M + N;            // component width
    localparam int c_qw   = c_dw + N;         // dividend / unsigned quotient width
    localparam int c_cntw = $clog2(c_qw + 1);
    localparam int c_hw   = SCR_W / 2;
    localparam int c_hh   = SCR_H / 2;
    localparam logic [c_cntw-1:0] c_last = c_cntw'(c_qw - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIV_X = 3'd1,
        S_DIV_Y = 3'd2,
        S_SCALE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_dw-1:0]     r_x, r_y, r_z, r_w;
    logic                r_prep;              // first DIV_X cycle: w check and divider load
    logic [c_dw-1:0]     r_rem;
    logic [c_qw-1:0]     r_dq;                // dividend shifting out, quotient shifting in
    logic [c_dw-1:0]     r_div;
    logic [c_cntw-1:0]   r_cnt;
    logic signed [c_qw:0] r_qx, r_qy;

    logic [c_dw:0]       w_shift;
    logic                w_ge;
    logic [c_dw-1:0]     w_sub;
    logic [c_dw-1:0]     w_rem_next;
    logic [c_qw-1:0]     w_dq_next;
    logic                w_last;
    logic                w_wnp;

    logic signed [31:0]  w_qx32, w_qy32, w_mx, w_my, w_sxf, w_syf;
    logic [CW-1:0]       w_sx_sat, w_sy_sat;
    logic                w_clip_x, w_clip_y;

    // Magnitude of a two's-complement component; the most negative value maps
    // to 2**(c_dw-1), which still fits c_dw unsigned bits.
    function automatic logic [c_dw-1:0] f_mag(input logic [c_dw-1:0] v);
        return v[c_dw-1] ? (~v + 1'b1) : v;
    endfunction

    // Re-apply the sign of the dividend to the unsigned quotient.
    function automatic logic signed [c_qw:0] f_sq(input logic [c_qw-1:0] q, input logic neg);
        logic [c_qw:0] e;
        e = {1'b0, q};
        return $signed(neg ? (~e + 1'b1) : e);
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift    = {r_rem, r_dq[c_qw-1]};
        w_ge       = (w_shift >= {1'b0, r_div});
        w_sub      = w_shift[c_dw-1:0] - r_div;
        w_rem_next = w_ge ? w_sub : w_shift[c_dw-1:0];
        w_dq_next  = {r_dq[c_qw-2:0], w_ge};
        w_last     = (r_cnt == c_last);
        w_wnp      = r_w[c_dw-1] | (r_w == '0);
    end

    // Viewport map of the NDC quotients followed by clamping to the screen.
    always_comb begin
        w_qx32   = {{(32-c_qw-1){r_qx[c_qw]}}, r_qx};
        w_qy32   = {{(32-c_qw-1){r_qy[c_qw]}}, r_qy};
        w_mx     = w_qx32 * c_hw;
        w_my     = w_qy32 * c_hh;
        w_sxf    = c_hw + (w_mx >>> N);
        w_syf    = c_hh - (w_my >>> N);
        w_sx_sat = w_sxf[CW-1:0];
        w_sy_sat = w_syf[CW-1:0];
        w_clip_x = 1'b0;
        w_clip_y = 1'b0;
        if (w_sxf < 0) begin
            w_sx_sat = '0;
            w_clip_x = 1'b1;
        end else if (w_sxf > SCR_W - 1) begin
            w_sx_sat = CW'(SCR_W - 1);
            w_clip_x = 1'b1;
        end
        if (w_syf < 0) begin
            w_sy_sat = '0;
            w_clip_y = 1'b1;
        end else if (w_syf > SCR_H - 1) begin
            w_sy_sat = CW'(SCR_H - 1);
            w_clip_y = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_DIV_X;
            S_DIV_X: begin
                if (r_prep) begin
                    if (w_wnp) w_state_next = S_OUT;
                end else if (w_last) begin
                    w_state_next = S_DIV_Y;
                end
            end
            S_DIV_Y: if (w_last) w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture, divider iterations, quotient storage and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_w      <= '0;
            r_prep   <= 1'b0;
            r_rem    <= '0;
            r_dq     <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_qx     <= '0;
            r_qy     <= '0;
            out_sx   <= '0;
            out_sy   <= '0;
            out_z    <= '0;
            out_clip <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x    <= in_x;
                        r_y    <= in_y;
                        r_z    <= in_z;
                        r_w    <= in_w;
                        r_prep <= 1'b1;
                    end
                end
                S_DIV_X: begin
                    if (r_prep) begin
                        r_prep <= 1'b0;
                        if (w_wnp) begin
                            out_sx   <= '0;
                            out_sy   <= '0;
                            out_z    <= r_z;
                            out_clip <= 1'b1;
                        end else begin
                            r_rem <= '0;
                            r_dq  <= {f_mag(r_x), {N{1'b0}}};
                            r_div <= f_mag(r_w);
                            r_cnt <= '0;
                        end
                    end else if (w_last) begin
                        r_qx  <= f_sq(w_dq_next, r_x[c_dw-1]);
                        r_rem <= '0;
                        r_dq  <= {f_mag(r_y), {N{1'b0}}};
                        r_cnt <= '0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dq  <= w_dq_next;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV_Y: begin
                    r_rem <= w_rem_next;
                    r_dq  <= w_dq_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_qy <= f_sq(w_dq_next, r_y[c_dw-1]);
                end
                S_SCALE: begin
                    out_sx   <= w_sx_sat;
                    out_sy   <= w_sy_sat;
                    out_z    <= r_z;
                    out_clip <= w_clip_x | w_clip_y;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vertex_viewport_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_vertex_viewport_mapper
// Description : Directed-vector scoreboard bench for vertex_viewport_mapper.
//               Stimulus pushes expected screen vertices; a monitor pops and
//               compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vertex_viewport_mapper;

    localparam int c_dw = 14;

    typedef struct {
        logic [9:0]      sx;
        logic [9:0]      sy;
        logic [c_dw-1:0] z;
        logic            clip;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [c_dw-1:0] in_x, in_y, in_z, in_w;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      out_sx, out_sy;
    logic [c_dw-1:0] out_z;
    logic            out_clip;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    vertex_viewport_mapper #(
        .M(10), .N(4), .SCR_W(640), .SCR_H(480), .CW(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sx    (out_sx),
        .out_sy    (out_sy),
        .out_z     (out_z),
        .out_clip  (out_clip)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample just before each rising edge and score every transfer.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: sx=%0d sy=%0d z=%0d clip=%0d with empty scoreboard",
                             out_sx, out_sy, out_z, out_clip);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (out_sx !== e.sx || out_sy !== e.sy || out_z !== e.z || out_clip !== e.clip) begin
                        errors++;
                        $display("FAIL vertex_out: got sx=%0d sy=%0d z=%0d clip=%0d, expected sx=%0d sy=%0d z=%0d clip=%0d",
                                 out_sx, out_sy, out_z, out_clip, e.sx, e.sy, e.z, e.clip);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Present one vertex, optionally push its expected result, and optionally
    // measure cycles from the accepting edge to out_valid.
    task automatic send(input logic [c_dw-1:0] x, y, z, w,
                        input int esx, esy, input logic eclip,
                        input bit push, input int lat);
        int   guard;
        int   n;
        exp_t e;
        @(negedge clk);
        in_x = x; in_y = y; in_z = z; in_w = w;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, guard);
        end
        if (push) begin
            e.sx = 10'(esx); e.sy = 10'(esy); e.z = z; e.clip = eclip;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (lat > 0) begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end while (!out_valid && n < 100);
            check("latency", n, lat);
            check("in_ready_busy", int'(in_ready), 0);
        end
    endtask

    initial begin : stim
        logic [9:0]      hold_sx, hold_sy;
        logic [c_dw-1:0] hold_z;
        logic            hold_clip;
        int              guard;
        int              stable;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0; in_w = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_outputs", int'({out_sx, out_sy, out_z, out_clip}), 0);
        rst_n = 1'b1;

        // Centre, off-centre, clamping, truncation toward zero, extreme values.
        send(14'(0),     14'(0),   14'(5),  14'(16), 320, 240, 1'b0, 1'b1, 38);
        send(14'(16),    14'(16),  14'(7),  14'(32), 480, 120, 1'b0, 1'b1, 38);
        send(-14'sd16,   -14'sd16, -14'sd3, 14'(16), 0,   479, 1'b1, 1'b1, 38);
        send(-14'sd1,    -14'sd1,  14'(0),  14'(3),  220, 315, 1'b0, 1'b1, 38);
        send(14'(1),     14'(0),   14'(6),  14'(3),  420, 240, 1'b0, 1'b1, 38);
        send(14'(7),     14'(0),   14'(8),  14'(2),  639, 240, 1'b1, 1'b1, 38);
        send(-14'sd8192, 14'(0),   14'(12), 14'(16), 0,   240, 1'b1, 1'b1, 38);

        // Rejected vertices: w == 0 and w < 0.
        send(14'(16), 14'(16), 14'(9),  14'(0),    0, 0, 1'b1, 1'b1, 1);
        send(14'(16), 14'(16), 14'(11), -14'sd16, 0, 0, 1'b1, 1'b1, 1);

        // Backpressure: hold the result for 10 cycles.
        @(negedge clk);
        out_ready = 1'b0;
        send(14'(16), -14'sd16, 14'(1), 14'(32), 480, 360, 1'b0, 1'b1, 38);
        hold_sx = out_sx; hold_sy = out_sy; hold_z = out_z; hold_clip = out_clip;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_sx !== hold_sx || out_sy !== hold_sy ||
                out_z !== hold_z || out_clip !== hold_clip) stable = 0;
        end
        check("backpressure_stable", stable, 1);
        check("backpressure_sx", int'(out_sx), 480);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);
        check("release_out_valid", int'(out_valid), 0);
        check("release_retain_sy", int'(out_sy), 360);

        // Back-to-back vertices, delivered in order.
        send(14'(0),  14'(0),  14'(2), 14'(16), 320, 240, 1'b0, 1'b1, 0);
        send(14'(16), 14'(16), 14'(3), 14'(32), 480, 120, 1'b0, 1'b1, 0);
        send(14'(0),  14'(0),  14'(4), 14'(0),  0,   0,   1'b1, 1'b1, 0);
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("burst_drained", sb_q.size(), 0);

        // Reset while the vertex is in DIV_Y: nothing may be emitted for it.
        send(14'(16), 14'(16), 14'(13), 14'(32), 0, 0, 1'b0, 1'b0, 0);
        repeat (25) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        check("midreset_outputs", int'({out_sx, out_sy, out_z, out_clip}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_idle", int'(in_ready), 1);

        // Recovery after reset.
        send(14'(16), 14'(16), 14'(14), 14'(32), 480, 120, 1'b0, 1'b1, 38);
        guard = 0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
